sram_ctrl: RTL and testbench

//  8 KB single-port on-chip SRAM block (2048 x 32-bit words) with a zero-latency

---
 rtl/sram_ctrl_pkg.sv | 29 ++
 rtl/sram_mbist_engine.sv | 146 ++++++++++++++
 rtl/sram_ctrl.sv | 87 ++++++++
 tb/tb_sram_ctrl.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// sram_ctrl_pkg
// Shared constants and types for the 8 KB local data RAM and its MBIST engine.
//   ADDR_W / DATA_W / BE_W : byte-address, data and byte-enable widths
//   DEPTH / IDX_W          : number of 32-bit words and word-index width
//   PAT0 / PAT1            : March background patterns (all zeros / all ones)
//   mbist_state_e          : MBIST sequencer states
// ---------------------------------------------------------------------------
package sram_ctrl_pkg;

   localparam int ADDR_W = 13;
   localparam int DATA_W = 32;
   localparam int BE_W   = DATA_W / 8;
   localparam int DEPTH  = 2048;
   localparam int IDX_W  = 11;

   localparam logic [DATA_W-1:0] PAT0 = '0;
   localparam logic [DATA_W-1:0] PAT1 = '1;

   typedef enum logic [2:0] {
      MB_IDLE = 3'd0,
      MB_W0   = 3'd1,
      MB_R0W1 = 3'd2,
      MB_R1W0 = 3'd3,
      MB_R0   = 3'd4,
      MB_DONE = 3'd5
   } mbist_state_e;

endpackage

// File: rtl/sram_mbist_engine.sv
// ---------------------------------------------------------------------------
// sram_mbist_engine
// March-type self test: W0 (up), R0W1 (up), R1W0 (down), R0 (down), one word
// per cycle. Fused steps compare the word read this cycle and write the new
// pattern at the same edge.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   i_en            : level enable; falling aborts / releases DONE
//   i_pd_en         : power domain on (needed to start; 0 stalls)
//   i_ret_en        : retention (1 stalls)
//   i_rdata         : array read data at o_idx
//   o_idx           : array word index driven while not idle
//   o_we / o_wdata  : full-word array write request
//   o_done          : in DONE state
//   o_fail          : sticky mismatch flag
//   o_fail_addr     : byte address of first failing word
//   o_state         : current state (debug / idle decode for the top)
// ---------------------------------------------------------------------------
module sram_mbist_engine
   import sram_ctrl_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              i_en,
   input  logic              i_pd_en,
   input  logic              i_ret_en,
   input  logic [DATA_W-1:0] i_rdata,
   output logic [IDX_W-1:0]  o_idx,
   output logic              o_we,
   output logic [DATA_W-1:0] o_wdata,
   output logic              o_done,
   output logic              o_fail,
   output logic [ADDR_W-1:0] o_fail_addr,
   output logic [2:0]        o_state
);

   mbist_state_e      r_state, w_state_nxt;
   logic [IDX_W-1:0]  r_idx, w_idx_nxt;
   logic              r_fail, w_fail_nxt;
   logic [ADDR_W-1:0] r_fail_addr, w_fail_addr_nxt;
   logic              w_chk;
   logic [DATA_W-1:0] w_exp;
   logic              w_last, w_first, w_stall;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= MB_IDLE;
         r_idx       <= '0;
         r_fail      <= 1'b0;
         r_fail_addr <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_idx       <= w_idx_nxt;
         r_fail      <= w_fail_nxt;
         r_fail_addr <= w_fail_addr_nxt;
      end
   end

   always_comb begin
      w_state_nxt     = r_state;
      w_idx_nxt       = r_idx;
      w_fail_nxt      = r_fail;
      w_fail_addr_nxt = r_fail_addr;
      o_we            = 1'b0;
      o_wdata         = PAT0;
      w_chk           = 1'b0;
      w_exp           = PAT0;
      w_last          = (r_idx == IDX_W'(DEPTH - 1));
      w_first         = (r_idx == '0);
      w_stall         = !i_pd_en || i_ret_en;

      case (r_state)
         MB_IDLE: begin
            if (i_en && i_pd_en) begin
               w_state_nxt     = MB_W0;
               w_idx_nxt       = '0;
               w_fail_nxt      = 1'b0;
               w_fail_addr_nxt = '0;
            end
         end
         MB_DONE: begin
            if (!i_en) w_state_nxt = MB_IDLE;
         end
         default: begin
            // Abort takes priority over a stall; a stall freezes everything.
            if (!i_en) begin
               w_state_nxt = MB_IDLE;
            end else if (!w_stall) begin
               case (r_state)
                  MB_W0: begin
                     o_we    = 1'b1;
                     o_wdata = PAT0;
                     if (w_last) begin
                        w_state_nxt = MB_R0W1;
                        w_idx_nxt   = '0;
                     end else begin
                        w_idx_nxt = r_idx + IDX_W'(1);
                     end
                  end
                  MB_R0W1: begin
                     w_chk   = 1'b1;
                     w_exp   = PAT0;
                     o_we    = 1'b1;
                     o_wdata = PAT1;
                     // Descending pass starts at the top word, already in r_idx.
                     if (w_last) w_state_nxt = MB_R1W0;
                     else        w_idx_nxt   = r_idx + IDX_W'(1);
                  end
                  MB_R1W0: begin
                     w_chk   = 1'b1;
                     w_exp   = PAT1;
                     o_we    = 1'b1;
                     o_wdata = PAT0;
                     if (w_first) begin
                        w_state_nxt = MB_R0;
                        w_idx_nxt   = IDX_W'(DEPTH - 1);
                     end else begin
                        w_idx_nxt = r_idx - IDX_W'(1);
                     end
                  end
                  MB_R0: begin
                     w_chk = 1'b1;
                     w_exp = PAT0;
                     if (w_first) w_state_nxt = MB_DONE;
                     else         w_idx_nxt   = r_idx - IDX_W'(1);
                  end
                  default: w_state_nxt = MB_IDLE;
               endcase
            end
         end
      endcase

      // Only the first mismatch records its address; the run carries on.
      if (w_chk && (i_rdata != w_exp)) begin
         w_fail_nxt = 1'b1;
         if (!r_fail) w_fail_addr_nxt = {r_idx, 2'b00};
      end
   end

   assign o_idx       = r_idx;
   assign o_done      = (r_state == MB_DONE);
   assign o_fail      = r_fail;
   assign o_fail_addr = r_fail_addr;
   assign o_state     = r_state;

endmodule

// File: rtl/sram_ctrl.sv
// ---------------------------------------------------------------------------
// sram_ctrl
// 8 KB (2048 x 32) single-port local data RAM with zero-latency reads,
// per-byte writes, built-in March MBIST and retention / power-domain gating.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   sram_req / sram_we       : access request, 1 = write
//   sram_be                  : byte enables (bit i -> wdata[8i+7:8i])
//   sram_addr                : byte address, word index = addr[12:2]
//   sram_wdata / sram_rdata  : write data / combinational read data
//   sram_ready               : high while MBIST is idle
//   mbist_en                 : run MBIST while high
//   mbist_done / mbist_fail  : MBIST status
//   mbist_fail_addr          : byte address of first failing word
//   ret_en                   : retention, blocks writes only
//   pd_en                    : power domain on; 0 blocks all access
// Handshake: an access is taken in any cycle where sram_req and sram_ready
// are both high; there is no back-pressure beyond MBIST, and requests made
// while sram_ready is low are dropped, not queued.
// ---------------------------------------------------------------------------
module sram_ctrl
   import sram_ctrl_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              sram_req,
   input  logic              sram_we,
   input  logic [BE_W-1:0]   sram_be,
   input  logic [ADDR_W-1:0] sram_addr,
   input  logic [DATA_W-1:0] sram_wdata,
   output logic [DATA_W-1:0] sram_rdata,
   output logic              sram_ready,
   input  logic              mbist_en,
   output logic              mbist_done,
   output logic              mbist_fail,
   output logic [ADDR_W-1:0] mbist_fail_addr,
   input  logic              ret_en,
   input  logic              pd_en
);

   logic [DATA_W-1:0] r_mem [DEPTH];

   logic [2:0]        w_mb_state;
   logic [IDX_W-1:0]  w_mb_idx;
   logic              w_mb_we;
   logic [DATA_W-1:0] w_mb_wdata;
   logic              w_idle;
   logic [IDX_W-1:0]  w_arr_idx;
   logic [DATA_W-1:0] w_arr_rdata;
   logic              w_fn_we;

   sram_mbist_engine u_mbist (
      .clk         (clk),
      .rst         (rst),
      .i_en        (mbist_en),
      .i_pd_en     (pd_en),
      .i_ret_en    (ret_en),
      .i_rdata     (w_arr_rdata),
      .o_idx       (w_mb_idx),
      .o_we        (w_mb_we),
      .o_wdata     (w_mb_wdata),
      .o_done      (mbist_done),
      .o_fail      (mbist_fail),
      .o_fail_addr (mbist_fail_addr),
      .o_state     (w_mb_state)
   );

   assign w_idle      = (w_mb_state == MB_IDLE);
   // The engine owns the single array port whenever it is not idle.
   assign w_arr_idx   = w_idle ? sram_addr[ADDR_W-1:2] : w_mb_idx;
   assign w_arr_rdata = r_mem[w_arr_idx];
   assign w_fn_we     = w_idle && sram_req && sram_we && pd_en && !ret_en;

   always_ff @(posedge clk) begin
      if (w_fn_we) begin
         for (int b = 0; b < BE_W; b++) begin
            if (sram_be[b]) r_mem[w_arr_idx][8*b +: 8] <= sram_wdata[8*b +: 8];
         end
      end else if (w_mb_we) begin
         r_mem[w_arr_idx] <= w_mb_wdata;
      end
   end

   assign sram_ready = w_idle;
   assign sram_rdata = (sram_req && !sram_we && pd_en && w_idle) ? w_arr_rdata : '0;

endmodule

// File: tb/tb_sram_ctrl.sv
module tb_sram_ctrl;
   import sram_ctrl_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        sram_req, sram_we;
   logic [3:0]  sram_be;
   logic [12:0] sram_addr;
   logic [31:0] sram_wdata, sram_rdata;
   logic        sram_ready;
   logic        mbist_en, mbist_done, mbist_fail;
   logic [12:0] mbist_fail_addr;
   logic        ret_en, pd_en;

   int checks   = 0;
   int failures = 0;

   logic [31:0] exp_q[$];
   logic [31:0] model_mem [2048];
   logic [3:0]  model_vld [2048];

   typedef struct {
      logic        req, we;
      logic [3:0]  be;
      logic [12:0] addr;
      logic [31:0] wdata;
      logic        ret, pd;
      logic [31:0] exp_rdata;
   } vec_t;
   vec_t tbl[$];

   sram_ctrl dut (
      .clk(clk), .rst(rst),
      .sram_req(sram_req), .sram_we(sram_we), .sram_be(sram_be),
      .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
      .sram_ready(sram_ready),
      .mbist_en(mbist_en), .mbist_done(mbist_done), .mbist_fail(mbist_fail),
      .mbist_fail_addr(mbist_fail_addr),
      .ret_en(ret_en), .pd_en(pd_en)
   );

   // clock
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic req, we, input logic [3:0] be,
                               input logic [12:0] addr, input logic [31:0] wdata,
                               input logic ret, pd, input logic [31:0] exp_rdata);
      vec_t v;
      v.req = req; v.we = we; v.be = be; v.addr = addr; v.wdata = wdata;
      v.ret = ret; v.pd = pd; v.exp_rdata = exp_rdata;
      return v;
   endfunction

   // Drive one cycle's inputs after the falling edge; outputs settle by #1.
   task automatic drive(input logic req, we, input logic [3:0] be, input logic [12:0] addr,
                        input logic [31:0] wdata, input logic ret, pd);
      @(negedge clk);
      sram_req = req; sram_we = we; sram_be = be; sram_addr = addr;
      sram_wdata = wdata; ret_en = ret; pd_en = pd;
      #1;
   endtask

   task automatic idle_bus();
      drive(1'b0, 1'b0, 4'h0, 13'h0, 32'h0, 1'b0, 1'b1);
   endtask

   // Waits for mbist_done; optional pd_en stall window partway through.
   task automatic wait_done(input string name, input bit do_stall);
      bit seen = 0;
      for (int c = 1; c <= 10000; c++) begin
         @(negedge clk);
         if (do_stall && c == 100) pd_en = 1'b0;
         if (do_stall && c == 150) pd_en = 1'b1;
         #1;
         if (c == 10) begin
            check({name, "_ready_busy"}, {31'h0, sram_ready}, 32'h0);
            check({name, "_rdata_busy"}, sram_rdata, 32'h0);
         end
         if (mbist_done) begin
            seen = 1;
            break;
         end
      end
      check({name, "_done_in_budget"}, {31'h0, seen}, 32'h1);
   endtask

   task automatic release_en(input string name, input logic exp_fail, input logic [12:0] exp_fa);
      @(negedge clk);
      mbist_en = 1'b0;
      #1;
      check({name, "_done_held"}, {31'h0, mbist_done}, 32'h1);
      @(negedge clk);
      #1;
      check({name, "_done_clr"}, {31'h0, mbist_done}, 32'h0);
      check({name, "_ready_back"}, {31'h0, sram_ready}, 32'h1);
      check({name, "_fail_kept"}, {31'h0, mbist_fail}, {31'h0, exp_fail});
      check({name, "_fail_addr_kept"}, {19'h0, mbist_fail_addr}, {19'h0, exp_fa});
   endtask

   initial begin
      rst = 1'b1; mbist_en = 1'b0;
      sram_req = 0; sram_we = 0; sram_be = 0; sram_addr = 0; sram_wdata = 0;
      ret_en = 0; pd_en = 1;
      for (int i = 0; i < 2048; i++) begin
         model_mem[i] = 32'h0;
         model_vld[i] = 4'h0;
      end

      // reset state
      repeat (2) @(negedge clk);
      #1;
      check("rst_done", {31'h0, mbist_done}, 32'h0);
      check("rst_fail", {31'h0, mbist_fail}, 32'h0);
      check("rst_fail_addr", {19'h0, mbist_fail_addr}, 32'h0);
      check("rst_ready", {31'h0, sram_ready}, 32'h1);
      rst = 1'b0;

      // directed table
      tbl.push_back(mk(1, 1, 4'hF, 13'h0000, 32'hDEADBEEF, 0, 1, 32'h0));
      tbl.push_back(mk(1, 0, 4'h0, 13'h0000, 32'h0,        0, 1, 32'hDEADBEEF));
      tbl.push_back(mk(1, 0, 4'h0, 13'h0003, 32'h0,        0, 1, 32'hDEADBEEF));
      tbl.push_back(mk(1, 1, 4'h0, 13'h0000, 32'h0,        0, 1, 32'h0));
      tbl.push_back(mk(1, 0, 4'h0, 13'h0000, 32'h0,        0, 1, 32'hDEADBEEF));
      tbl.push_back(mk(1, 1, 4'hF, 13'h1FFC, 32'hDEADBEEF, 0, 1, 32'h0));
      tbl.push_back(mk(1, 0, 4'h0, 13'h1FFC, 32'h0,        0, 1, 32'hDEADBEEF));
      tbl.push_back(mk(1, 1, 4'hF, 13'h0100, 32'h0,        0, 1, 32'h0));
      tbl.push_back(mk(1, 1, 4'h1, 13'h0100, 32'h000000AA, 0, 1, 32'h0));
      tbl.push_back(mk(1, 0, 4'h0, 13'h0100, 32'h0,        0, 1, 32'h000000AA));
      tbl.push_back(mk(1, 1, 4'h2, 13'h0100, 32'h0000BB00, 0, 1, 32'h0));
      tbl.push_back(mk(1, 0, 4'h0, 13'h0100, 32'h0,        0, 1, 32'h0000BBAA));
      tbl.push_back(mk(1, 1, 4'h4, 13'h0100, 32'h00CC0000, 0, 1, 32'h0));
      tbl.push_back(mk(1, 0, 4'h0, 13'h0100, 32'h0,        0, 1, 32'h00CCBBAA));
      tbl.push_back(mk(1, 1, 4'h8, 13'h0100, 32'hDD000000, 0, 1, 32'h0));
      tbl.push_back(mk(1, 0, 4'h0, 13'h0100, 32'h0,        0, 1, 32'hDDCCBBAA));
      tbl.push_back(mk(1, 1, 4'hF, 13'h0300, 32'hAAAAAAAA, 0, 1, 32'h0));
      tbl.push_back(mk(1, 1, 4'hF, 13'h0304, 32'hBBBBBBBB, 0, 1, 32'h0));
      tbl.push_back(mk(1, 1, 4'hF, 13'h0308, 32'hCCCCCCCC, 0, 1, 32'h0));
      tbl.push_back(mk(1, 0, 4'h0, 13'h0300, 32'h0,        0, 1, 32'hAAAAAAAA));
      tbl.push_back(mk(1, 0, 4'h0, 13'h0304, 32'h0,        0, 1, 32'hBBBBBBBB));
      tbl.push_back(mk(1, 0, 4'h0, 13'h0308, 32'h0,        0, 1, 32'hCCCCCCCC));
      tbl.push_back(mk(0, 0, 4'h0, 13'h0300, 32'h0,        0, 1, 32'h0));
      tbl.push_back(mk(1, 1, 4'hF, 13'h0400, 32'h55555555, 0, 1, 32'h0));
      tbl.push_back(mk(1, 1, 4'hF, 13'h0400, 32'hAAAAAAAA, 1, 1, 32'h0));
      tbl.push_back(mk(1, 0, 4'h0, 13'h0400, 32'h0,        1, 1, 32'h55555555));
      tbl.push_back(mk(1, 1, 4'hF, 13'h0400, 32'h99999999, 0, 0, 32'h0));
      tbl.push_back(mk(1, 0, 4'h0, 13'h0400, 32'h0,        0, 0, 32'h0));
      tbl.push_back(mk(1, 0, 4'h0, 13'h0400, 32'h0,        0, 1, 32'h55555555));
      foreach (tbl[i]) begin
         drive(tbl[i].req, tbl[i].we, tbl[i].be, tbl[i].addr, tbl[i].wdata, tbl[i].ret, tbl[i].pd);
         check($sformatf("vec%0d_rdata", i), sram_rdata, tbl[i].exp_rdata);
         check($sformatf("vec%0d_ready", i), {31'h0, sram_ready}, 32'h1);
      end

      // MBIST, healthy array, with a power-off stall window
      idle_bus();
      mbist_en = 1'b1;
      wait_done("mb_ok", 1'b1);
      check("mb_ok_fail", {31'h0, mbist_fail}, 32'h0);
      release_en("mb_ok", 1'b0, 13'h0);
      begin
         logic [12:0] zaddr[5];
         zaddr[0] = 13'h0000; zaddr[1] = 13'h0100; zaddr[2] = 13'h0300;
         zaddr[3] = 13'h0400; zaddr[4] = 13'h1FFC;
         for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b0, 4'h0, zaddr[i], 32'h0, 1'b0, 1'b1);
            check($sformatf("post_mbist_zero_%0d", i), sram_rdata, 32'h0);
         end
      end
      for (int i = 0; i < 2048; i++) begin
         model_mem[i] = 32'h0;
         model_vld[i] = 4'hF;
      end

      // randomized traffic against the array model
      for (int n = 0; n < 400; n++) begin
         int          r, idx;
         logic        req, we, ret, pd;
         logic [3:0]  be;
         logic [31:0] wd, exp;
         r   = int'($urandom_range(0, 15));
         idx = (r < 8) ? r : 2032 + r;
         req = ($urandom_range(0, 9) != 0);
         we  = $urandom_range(0, 1) == 1;
         be  = 4'($urandom_range(0, 15));
         wd  = $urandom;
         ret = ($urandom_range(0, 7) == 0);
         pd  = ($urandom_range(0, 7) != 0);
         if (req && !we) exp_q.push_back(pd ? model_mem[idx] : 32'h0);
         else            exp_q.push_back(32'h0);
         drive(req, we, be, 13'({idx, 2'($urandom_range(0, 3))}), wd, ret, pd);
         exp = exp_q.pop_front();
         if (!(req && !we && pd) || model_vld[idx] == 4'hF)
            check($sformatf("rnd%0d_rdata", n), sram_rdata, exp);
         if (req && we && pd && !ret) begin
            for (int b = 0; b < 4; b++) begin
               if (be[b]) begin
                  model_mem[idx][8*b +: 8] = wd[8*b +: 8];
                  model_vld[idx][b] = 1'b1;
               end
            end
         end
      end

      // MBIST with a read path stuck at zero: first miss is R1W0's first word
      idle_bus();
      force dut.w_arr_rdata = 32'h0;
      mbist_en = 1'b1;
      wait_done("mb_stuck", 1'b0);
      release dut.w_arr_rdata;
      check("mb_stuck_fail", {31'h0, mbist_fail}, 32'h1);
      check("mb_stuck_fail_addr", {19'h0, mbist_fail_addr}, 32'h1FFC);
      release_en("mb_stuck", 1'b1, 13'h1FFC);

      // restart clears fail; abort mid-run returns to idle without done
      @(negedge clk);
      mbist_en = 1'b1;
      repeat (5) @(negedge clk);
      #1;
      check("abort_fail_cleared", {31'h0, mbist_fail}, 32'h0);
      check("abort_fail_addr_cleared", {19'h0, mbist_fail_addr}, 32'h0);
      mbist_en = 1'b0;
      @(negedge clk);
      #1;
      check("abort_ready", {31'h0, sram_ready}, 32'h1);
      check("abort_done", {31'h0, mbist_done}, 32'h0);

      // reset in the middle of a failing run
      force dut.w_arr_rdata = 32'h0;
      mbist_en = 1'b1;
      begin
         bit seen = 0;
         for (int c = 0; c < 10000; c++) begin
            @(negedge clk);
            #1;
            if (mbist_fail) begin
               seen = 1;
               break;
            end
         end
         check("rst_run_fail_seen", {31'h0, seen}, 32'h1);
      end
      rst = 1'b1;
      mbist_en = 1'b0;
      @(negedge clk);
      #1;
      release dut.w_arr_rdata;
      check("midrun_rst_done", {31'h0, mbist_done}, 32'h0);
      check("midrun_rst_fail", {31'h0, mbist_fail}, 32'h0);
      check("midrun_rst_fail_addr", {19'h0, mbist_fail_addr}, 32'h0);
      check("midrun_rst_ready", {31'h0, sram_ready}, 32'h1);
      rst = 1'b0;
      @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
